md_sched: RTL
=============

MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 Parameter MUL_CYC, default 5, busy cycles for mult/multu (legal 1-15).
REQ-002 Parameter DIV_CYC, default 10, busy cycles for div/divu (legal 1-15).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  EX-stage MDU instruction valid this cycle.
REQ-006 op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
REQ-007 A  input  32  EX-stage rs operand (forwarded).
REQ-008 B  input  32  EX-stage rt operand (forwarded).
REQ-009 md_use_D  input  1  D-stage instruction is any MDU op.
REQ-010 busy  output  1  long operation in progress.
REQ-011 stall_D  output  1  freeze PC/IF_ID and bubble into ID_EX.
REQ-012 HI  output  32  architectural HI.
REQ-013 LO  output  32  architectural LO.
REQ-014 RD  output  32  mfhi/mflo read data for EX_MEM MDM_RD.

Function
REQ-015 States: IDLE, MUL, DIV; a 4-bit down-counter cnt; operand/op latches.
REQ-016 IDLE + start + op in {1,2}: latch A, B, op; cnt <= MUL_CYC; go MUL on the same edge.
REQ-017 IDLE + start + op in {3,4}: latch A, B, op; cnt <= DIV_CYC; go DIV on the same edge.
REQ-018 busy = (state != IDLE), registered; high for exactly MUL_CYC/DIV_CYC cycles after the accepting edge.
REQ-019 MUL/DIV: cnt decrements each edge; on the edge where cnt goes 1->0, write HI/LO and return to IDLE.
REQ-020 mult: {HI,LO} = signed 64-bit A*B; multu: unsigned 64-bit product.
REQ-021 div: LO = signed quotient truncated toward zero, HI = remainder with sign of A; divu: unsigned quotient/remainder.
REQ-022 div/divu with B == 0: HI and LO keep prior values; timing same as nonzero divide.
REQ-023 div with A = 0x80000000, B = 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-024 mthi/mtlo with start in IDLE: HI (resp. LO) <= A on that edge; no busy cycle.
REQ-025 start in MUL/DIV with any op: ignored, with no state, HI, LO, or latch change.
REQ-026 Late writes are dropped: mthi/mtlo arriving while busy are lost.
REQ-027 Pipeline prevents REQ-025/026 via stall_D.
REQ-028 RD combinational: op==7 & start -> HI; op==8 & start -> LO; else 0.
REQ-029 RD reflects committed HI/LO only; no bypass of an in-flight result.
REQ-030 stall_D combinational = md_use_D & (busy | (start & op in {1,2,3,4})).
REQ-031 After the final busy cycle, stall_D drops in the first cycle busy is low; a D-stage mfhi then reads the new value in EX.
REQ-032 Operands used are the latched copies; A/B changes after acceptance have no effect.

Reset
REQ-033 reset high at an edge: state IDLE, cnt 0, latches 0, HI 0, LO 0, busy 0.
REQ-034 With reset high, stall_D = 0 and RD = 0 regardless of inputs.
REQ-035 Reset has priority over start.
REQ-036 Reset mid-operation aborts with no HI/LO write.
REQ-037 Operation resumes the first edge after reset falls.

Verification
REQ-038 Signed mult: start, op=1, A=0xFFFFFFFE, B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-039 Signed div: start, op=3, A=-7, B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-040 Divide by zero: mthi A=0x11, mtlo A=0x22, then divu B=0 -> after 10 cycles HI=0x11, LO=0x22.
REQ-041 Stall: multu A=B=0x10000, md_use_D=1 held -> stall_D=1 on the start cycle plus 5 busy cycles.
REQ-042 After that stall: stall_D=0, then mfhi gives RD=1 and mflo gives RD=0.
REQ-043 Reset mid-op: mult issued, reset at busy cycle 3 -> next cycle busy=0, HI=LO=0, and no late write occurs.
REQ-044 Ignored start: a div issued while in MUL is ignored, and only the mult result commits.

Source files
------------

// File: rtl/md_sched_if.sv
// Bundle of EX-stage multiply/divide request lines and the scheduler's HI/LO/stall responses.
interface md_sched_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use_D;
  logic        busy;
  logic        stall_D;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] RD;

  modport master (output start, op, A, B, md_use_D,
                  input  busy, stall_D, HI, LO, RD);
  modport slave  (input  start, op, A, B, md_use_D,
                  output busy, stall_D, HI, LO, RD);
endinterface

// File: rtl/md_sched.sv
// Multiply/divide unit scheduler: multi-cycle mult/div with HI/LO commit at the end of the busy window.
module md_sched #(
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        mul_sx;
  logic [63:0] prod;
  logic        div_sx;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  logic        long_op;

  // Signed multiply done as a 64-bit product of sign-extended operands.
  always_comb begin
    mul_sx = (op_q == OP_MULT);
    prod   = {{32{mul_sx & a_q[31]}}, a_q} * {{32{mul_sx & b_q[31]}}, b_q};
  end

  // Signed divide via magnitudes; min/-1 falls out as 0x80000000 with no special case.
  always_comb begin
    div_sx = (op_q == OP_DIV);
    a_mag  = (div_sx && a_q[31]) ? -a_q : a_q;
    b_mag  = (div_sx && b_q[31]) ? -b_q : b_q;
    b_safe = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (div_sx && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
    rem    = (div_sx && a_q[31]) ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              op_d    = bus.op;
              a_d     = bus.A;
              b_d     = bus.B;
              cnt_d   = 4'(MUL_CYC);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = bus.op;
              a_d     = bus.A;
              b_d     = bus.B;
              cnt_d   = 4'(DIV_CYC);
              state_d = S_DIV;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    long_op     = bus.start && (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
    bus.busy    = (state_q != S_IDLE);
    bus.HI      = hi_q;
    bus.LO      = lo_q;
    bus.stall_D = !reset && bus.md_use_D && (bus.busy || long_op);
    bus.RD      = '0;
    if (!reset && bus.start) begin
      if (bus.op == OP_MFHI)      bus.RD = hi_q;
      else if (bus.op == OP_MFLO) bus.RD = lo_q;
    end
  end

endmodule
